// File: rtl/alt_vipitc131_pkg.sv
// Shared types for the IS2Vid mode-selection controller.
// Optional feature macro used by dependants: ALT_VIPITC131_INTERLACE_MATCH_EN.
package alt_vipitc131_pkg;

  localparam int unsigned VID_DIM_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WAIT_FRAME,
    ST_REQ,
    ST_LOCKED,
    ST_NO_MATCH
  } mode_state_e;

  // One video mode: either a captured header or a mode bank entry.
  typedef struct packed {
    logic [VID_DIM_W-1:0] width;
    logic [VID_DIM_W-1:0] height;
    logic                 interlaced;
    logic                 valid;
  } mode_rec_t;

endpackage

// File: rtl/alt_vipitc131_IS2Vid_mode_compare.sv
// Combinational header-vs-mode-bank-entry match.
// ALT_VIPITC131_INTERLACE_MATCH_EN defined: interlace flags must also agree.
// Undefined: only width and height are compared.
module alt_vipitc131_IS2Vid_mode_compare
  import alt_vipitc131_pkg::*;
(
  input  mode_rec_t hdr_i,
  input  mode_rec_t ent_i,
  output logic      match_o
);

  logic dims_eq;

`ifdef ALT_VIPITC131_INTERLACE_MATCH_EN
  // Entry is a match when it is in use and all geometry fields agree.
  always_comb begin
    dims_eq = (hdr_i.width == ent_i.width) && (hdr_i.height == ent_i.height);
    match_o = hdr_i.valid & ent_i.valid & dims_eq
              & (hdr_i.interlaced == ent_i.interlaced);
  end
`else
  logic unused_ilace;

  // Entry is a match when it is in use and width/height agree.
  always_comb begin
    unused_ilace = hdr_i.interlaced ^ ent_i.interlaced;
    dims_eq      = (hdr_i.width == ent_i.width) && (hdr_i.height == ent_i.height);
    match_o      = hdr_i.valid & ent_i.valid & dims_eq;
  end
`endif

endmodule

// File: rtl/alt_vipitc131_is2vid_mode_ctrl.sv
// IS2Vid mode-selection controller: searches the mode bank for the latest
// control-packet header, then switches the timing generator at the next frame
// boundary through a req/ack handshake. All outputs are registered.
// Optional feature macro: ALT_VIPITC131_INTERLACE_MATCH_EN (see compare block).
module alt_vipitc131_is2vid_mode_ctrl
  import alt_vipitc131_pkg::*;
#(
  parameter int unsigned NO_OF_MODES = 4,
  parameter int unsigned IDXW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hdr_valid,
  input  logic [VID_DIM_W-1:0] hdr_width,
  input  logic [VID_DIM_W-1:0] hdr_height,
  input  logic                 hdr_interlaced,
  output logic [IDXW-1:0]      mode_rd_addr,
  input  logic [VID_DIM_W-1:0] mode_width,
  input  logic [VID_DIM_W-1:0] mode_height,
  input  logic                 mode_interlaced,
  input  logic                 mode_valid,
  input  logic                 frame_start,
  output logic                 mode_change_req,
  output logic [IDXW-1:0]      mode_change_idx,
  input  logic                 mode_change_ack,
  output logic [IDXW-1:0]      active_idx,
  output logic                 mode_locked,
  output logic                 no_match
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NO_OF_MODES - 1);

  mode_state_e     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] target_q, target_d;
  logic [IDXW-1:0] active_q, active_d;
  mode_rec_t       hdr_q, hdr_d;
  mode_rec_t       pend_hdr_q, pend_hdr_d;
  logic            pend_q, pend_d;
  logic            act_lock_q, act_lock_d;
  logic            req_q, locked_q, nomatch_q;

  mode_rec_t hdr_in;
  mode_rec_t ent_in;
  logic      match;

  // Pack the live header and bank read data into mode records.
  always_comb begin
    hdr_in            = '0;
    hdr_in.width      = hdr_width;
    hdr_in.height     = hdr_height;
    hdr_in.interlaced = hdr_interlaced;
    hdr_in.valid      = 1'b1;
    ent_in            = '0;
    ent_in.width      = mode_width;
    ent_in.height     = mode_height;
    ent_in.interlaced = mode_interlaced;
    ent_in.valid      = mode_valid;
  end

  alt_vipitc131_IS2Vid_mode_compare u_cmp (
    .hdr_i   (hdr_q),
    .ent_i   (ent_in),
    .match_o (match)
  );

  // Next-state logic for the search / switch sequence.
  // act_lock_q remembers that the timing generator was locked when the search
  // was launched, so a restarted search may still short-circuit to LOCKED even
  // though mode_locked itself drops as soon as the search begins.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    target_d   = target_q;
    active_d   = active_q;
    hdr_d      = hdr_q;
    pend_hdr_d = pend_hdr_q;
    pend_d     = pend_q;
    act_lock_d = act_lock_q;
    unique case (state_q)
      ST_IDLE, ST_LOCKED, ST_NO_MATCH: begin
        if (hdr_valid) begin
          hdr_d   = hdr_in;
          idx_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (hdr_valid) begin
          hdr_d   = hdr_in;
          idx_d   = '0;
          state_d = ST_RD;
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (hdr_valid) begin
          hdr_d   = hdr_in;
          idx_d   = '0;
          state_d = ST_RD;
        end else if (match) begin
          if ((idx_q == active_q) && act_lock_q) begin
            state_d = ST_LOCKED;
          end else begin
            target_d = idx_q;
            state_d  = ST_WAIT_FRAME;
          end
        end else if (idx_q == LAST_IDX) begin
          act_lock_d = 1'b0;
          state_d    = ST_NO_MATCH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD;
        end
      end
      ST_WAIT_FRAME: begin
        if (hdr_valid) begin
          hdr_d   = hdr_in;
          idx_d   = '0;
          state_d = ST_RD;
        end else if (frame_start) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hdr_valid) begin
          pend_d     = 1'b1;
          pend_hdr_d = hdr_in;
        end
        if (mode_change_ack) begin
          active_d   = target_q;
          act_lock_d = 1'b1;
          if (hdr_valid || pend_q) begin
            hdr_d   = hdr_valid ? hdr_in : pend_hdr_q;
            pend_d  = 1'b0;
            idx_d   = '0;
            state_d = ST_RD;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; status flags are
  // registered from the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      target_q   <= '0;
      active_q   <= '0;
      hdr_q      <= '0;
      pend_hdr_q <= '0;
      pend_q     <= 1'b0;
      act_lock_q <= 1'b0;
      req_q      <= 1'b0;
      locked_q   <= 1'b0;
      nomatch_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      active_q   <= active_d;
      hdr_q      <= hdr_d;
      pend_hdr_q <= pend_hdr_d;
      pend_q     <= pend_d;
      act_lock_q <= act_lock_d;
      req_q      <= (state_d == ST_REQ);
      locked_q   <= (state_d == ST_LOCKED);
      nomatch_q  <= (state_d == ST_NO_MATCH);
    end
  end

  assign mode_rd_addr    = idx_q;
  assign mode_change_req = req_q;
  assign mode_change_idx = target_q;
  assign active_idx      = active_q;
  assign mode_locked     = locked_q;
  assign no_match        = nomatch_q;

endmodule

// File: tb/tb_alt_vipitc131_is2vid_mode_ctrl.sv
// Directed bench for the IS2Vid mode-selection controller.
// Bank: 0=720x480i, 1=1280x720p, 2=1920x1080p, 3 unused (holds 800x600p data).
// Honours ALT_VIPITC131_INTERLACE_MATCH_EN for the interlace scenario.
module tb_alt_vipitc131_is2vid_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0;
  logic [15:0] hdr_width = '0;
  logic [15:0] hdr_height = '0;
  logic        hdr_interlaced = 1'b0;
  logic [1:0]  mode_rd_addr;
  logic [15:0] mode_width = '0;
  logic [15:0] mode_height = '0;
  logic        mode_interlaced = 1'b0;
  logic        mode_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        mode_change_req;
  logic [1:0]  mode_change_idx;
  logic        mode_change_ack = 1'b0;
  logic [1:0]  active_idx;
  logic        mode_locked;
  logic        no_match;

  int tests = 0;
  int fails = 0;

  logic [15:0] bank_w [4];
  logic [15:0] bank_h [4];
  logic        bank_i [4];
  logic        bank_v [4];

  alt_vipitc131_is2vid_mode_ctrl #(.NO_OF_MODES(4), .IDXW(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .hdr_valid       (hdr_valid),
    .hdr_width       (hdr_width),
    .hdr_height      (hdr_height),
    .hdr_interlaced  (hdr_interlaced),
    .mode_rd_addr    (mode_rd_addr),
    .mode_width      (mode_width),
    .mode_height     (mode_height),
    .mode_interlaced (mode_interlaced),
    .mode_valid      (mode_valid),
    .frame_start     (frame_start),
    .mode_change_req (mode_change_req),
    .mode_change_idx (mode_change_idx),
    .mode_change_ack (mode_change_ack),
    .active_idx      (active_idx),
    .mode_locked     (mode_locked),
    .no_match        (no_match)
  );

  always #5 clk = ~clk;

  // Mode bank with one-cycle read latency.
  always @(posedge clk) begin
    mode_width      <= bank_w[mode_rd_addr];
    mode_height     <= bank_h[mode_rd_addr];
    mode_interlaced <= bank_i[mode_rd_addr];
    mode_valid      <= bank_v[mode_rd_addr];
  end

  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h, input logic il);
    hdr_valid = 1'b1; hdr_width = w; hdr_height = h; hdr_interlaced = il;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_ack();
    mode_change_ack = 1'b1;
    @(posedge clk); #1;
    mode_change_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (mode_rd_addr !== 2'd0) begin fails++; $display("FAIL rst_addr: got %0d want 0", mode_rd_addr); end
    tests++; if (mode_change_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0d want 0", mode_change_req); end
    tests++; if (mode_change_idx !== 2'd0) begin fails++; $display("FAIL rst_idx: got %0d want 0", mode_change_idx); end
    tests++; if (active_idx !== 2'd0) begin fails++; $display("FAIL rst_active: got %0d want 0", active_idx); end
    tests++; if (mode_locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %0d want 0", mode_locked); end
    tests++; if (no_match !== 1'b0) begin fails++; $display("FAIL rst_nomatch: got %0d want 0", no_match); end
  endtask

  // 1280x720p after reset: found at entry 1, switched at frame start.
  task automatic test_first_lock();
    send_hdr(16'd1280, 16'd720, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1 || c == 3) begin
        tests++; if (mode_rd_addr !== 2'((c - 1) / 2)) begin fails++; $display("FAIL lock_addr c%0d: got %0d want %0d", c, mode_rd_addr, (c - 1) / 2); end
      end
      if (c == 4) begin
        tests++; if (mode_change_idx !== 2'd0) begin fails++; $display("FAIL lock_idx_early: got %0d want 0", mode_change_idx); end
      end
      tests++; if (mode_change_req !== 1'b0) begin fails++; $display("FAIL lock_req_search c%0d: got %0d want 0", c, mode_change_req); end
    end
    tests++; if (mode_change_idx !== 2'd1) begin fails++; $display("FAIL lock_target: got %0d want 1", mode_change_idx); end
    // frame_start only matters in WAIT_FRAME; here it arrives right on time
    pulse_frame();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b1) begin fails++; $display("FAIL lock_req: got %0d want 1", mode_change_req); end
    tests++; if (active_idx !== 2'd0) begin fails++; $display("FAIL lock_active_pre: got %0d want 0", active_idx); end
    repeat (2) @(negedge clk);
    tests++; if (mode_change_req !== 1'b1 || mode_change_idx !== 2'd1) begin fails++; $display("FAIL lock_req_hold: got req=%0d idx=%0d want req=1 idx=1", mode_change_req, mode_change_idx); end
    pulse_ack();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b0) begin fails++; $display("FAIL lock_req_drop: got %0d want 0", mode_change_req); end
    tests++; if (active_idx !== 2'd1) begin fails++; $display("FAIL lock_active: got %0d want 1", active_idx); end
    tests++; if (mode_locked !== 1'b1) begin fails++; $display("FAIL lock_locked: got %0d want 1", mode_locked); end
    // stray ack / frame_start while locked must do nothing
    mode_change_ack = 1'b1;
    pulse_frame();
    mode_change_ack = 1'b0;
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b0 || active_idx !== 2'd1 || mode_locked !== 1'b1) begin fails++; $display("FAIL stray_ack: got req=%0d act=%0d lk=%0d want 0 1 1", mode_change_req, active_idx, mode_locked); end
  endtask

  // Same header while locked: back to LOCKED without a request.
  task automatic test_relock();
    send_hdr(16'd1280, 16'd720, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      tests++; if (mode_change_req !== 1'b0) begin fails++; $display("FAIL relock_req c%0d: got %0d want 0", c, mode_change_req); end
      if (c == 4) begin
        tests++; if (mode_locked !== 1'b0) begin fails++; $display("FAIL relock_early: got %0d want 0", mode_locked); end
      end
    end
    tests++; if (mode_locked !== 1'b1) begin fails++; $display("FAIL relock_locked: got %0d want 1", mode_locked); end
  endtask

  // 800x600 only exists in the unused entry 3: full sweep then no_match.
  task automatic test_no_match();
    send_hdr(16'd800, 16'd600, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c % 2 == 1 && c <= 7) begin
        tests++; if (mode_rd_addr !== 2'((c - 1) / 2)) begin fails++; $display("FAIL nm_addr c%0d: got %0d want %0d", c, mode_rd_addr, (c - 1) / 2); end
      end
      if (c == 8) begin
        tests++; if (no_match !== 1'b0) begin fails++; $display("FAIL nm_early: got %0d want 0", no_match); end
      end
    end
    tests++; if (no_match !== 1'b1) begin fails++; $display("FAIL nm_flag: got %0d want 1", no_match); end
    tests++; if (mode_locked !== 1'b0) begin fails++; $display("FAIL nm_locked: got %0d want 0", mode_locked); end
    tests++; if (active_idx !== 2'd1) begin fails++; $display("FAIL nm_active: got %0d want 1", active_idx); end
  endtask

  // Second header while waiting for frame start restarts the search; reset in WAIT_FRAME.
  task automatic test_restart_and_reset();
    send_hdr(16'd1920, 16'd1080, 1'b0);
    repeat (7) @(negedge clk);
    tests++; if (mode_change_idx !== 2'd2 || mode_rd_addr !== 2'd2) begin fails++; $display("FAIL rs_wait: got idx=%0d addr=%0d want 2 2", mode_change_idx, mode_rd_addr); end
    send_hdr(16'd1280, 16'd720, 1'b0);
    @(negedge clk);
    tests++; if (mode_rd_addr !== 2'd0) begin fails++; $display("FAIL rs_restart_addr: got %0d want 0", mode_rd_addr); end
    repeat (4) @(negedge clk);
    tests++; if (mode_change_idx !== 2'd1 || mode_change_req !== 1'b0) begin fails++; $display("FAIL rs_target: got idx=%0d req=%0d want 1 0", mode_change_idx, mode_change_req); end
    do_reset();
    @(negedge clk);
    tests++; if (mode_rd_addr !== 2'd0 || mode_change_idx !== 2'd0 || active_idx !== 2'd0) begin fails++; $display("FAIL rs_rst_idx: got addr=%0d idx=%0d act=%0d want 0 0 0", mode_rd_addr, mode_change_idx, active_idx); end
    tests++; if (mode_change_req !== 1'b0 || mode_locked !== 1'b0 || no_match !== 1'b0) begin fails++; $display("FAIL rs_rst_flags: got req=%0d lk=%0d nm=%0d want 0 0 0", mode_change_req, mode_locked, no_match); end
  endtask

  // Header during REQ is held pending; search resumes the cycle after ack.
  task automatic test_back_to_back();
    send_hdr(16'd1280, 16'd720, 1'b0);
    repeat (5) @(negedge clk);
    pulse_frame();
    @(negedge clk);
    send_hdr(16'd1920, 16'd1080, 1'b0);
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b1 || mode_change_idx !== 2'd1 || mode_rd_addr !== 2'd1) begin fails++; $display("FAIL b2b_hold: got req=%0d idx=%0d addr=%0d want 1 1 1", mode_change_req, mode_change_idx, mode_rd_addr); end
    pulse_ack();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b0 || active_idx !== 2'd1) begin fails++; $display("FAIL b2b_ack: got req=%0d act=%0d want 0 1", mode_change_req, active_idx); end
    tests++; if (mode_rd_addr !== 2'd0 || mode_locked !== 1'b0) begin fails++; $display("FAIL b2b_restart: got addr=%0d lk=%0d want 0 0", mode_rd_addr, mode_locked); end
    repeat (6) @(negedge clk);
    tests++; if (mode_change_idx !== 2'd2 || mode_change_req !== 1'b0) begin fails++; $display("FAIL b2b_target: got idx=%0d req=%0d want 2 0", mode_change_idx, mode_change_req); end
    pulse_frame();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b1 || mode_change_idx !== 2'd2) begin fails++; $display("FAIL b2b_req2: got req=%0d idx=%0d want 1 2", mode_change_req, mode_change_idx); end
    pulse_ack();
    @(negedge clk);
    tests++; if (active_idx !== 2'd2 || mode_locked !== 1'b1) begin fails++; $display("FAIL b2b_lock2: got act=%0d lk=%0d want 2 1", active_idx, mode_locked); end
  endtask

  // 720x480 progressive: entry 0 is interlaced.
  task automatic test_interlace();
    send_hdr(16'd720, 16'd480, 1'b0);
    repeat (3) @(negedge clk);
`ifdef ALT_VIPITC131_INTERLACE_MATCH_EN
    tests++; if (mode_rd_addr !== 2'd1 || mode_change_idx !== 2'd2) begin fails++; $display("FAIL il_c3: got addr=%0d idx=%0d want 1 2", mode_rd_addr, mode_change_idx); end
    repeat (6) @(negedge clk);
    tests++; if (no_match !== 1'b1 || active_idx !== 2'd2) begin fails++; $display("FAIL il_nomatch: got nm=%0d act=%0d want 1 2", no_match, active_idx); end
`else
    tests++; if (mode_rd_addr !== 2'd0 || mode_change_idx !== 2'd0) begin fails++; $display("FAIL il_c3: got addr=%0d idx=%0d want 0 0", mode_rd_addr, mode_change_idx); end
    repeat (6) @(negedge clk);
    tests++; if (no_match !== 1'b0 || mode_locked !== 1'b0 || mode_change_idx !== 2'd0) begin fails++; $display("FAIL il_match: got nm=%0d lk=%0d idx=%0d want 0 0 0", no_match, mode_locked, mode_change_idx); end
`endif
  endtask

  // Reset while requesting drops req on the next edge.
  task automatic test_reset_in_req();
    do_reset();
    send_hdr(16'd1280, 16'd720, 1'b0);
    repeat (5) @(negedge clk);
    pulse_frame();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b1) begin fails++; $display("FAIL rr_req: got %0d want 1", mode_change_req); end
    do_reset();
    @(negedge clk);
    tests++; if (mode_change_req !== 1'b0 || mode_change_idx !== 2'd0 || active_idx !== 2'd0) begin fails++; $display("FAIL rr_drop: got req=%0d idx=%0d act=%0d want 0 0 0", mode_change_req, mode_change_idx, active_idx); end
  endtask

  initial begin
    bank_w[0] = 16'd720;  bank_h[0] = 16'd480;  bank_i[0] = 1'b1; bank_v[0] = 1'b1;
    bank_w[1] = 16'd1280; bank_h[1] = 16'd720;  bank_i[1] = 1'b0; bank_v[1] = 1'b1;
    bank_w[2] = 16'd1920; bank_h[2] = 16'd1080; bank_i[2] = 1'b0; bank_v[2] = 1'b1;
    bank_w[3] = 16'd800;  bank_h[3] = 16'd600;  bank_i[3] = 1'b0; bank_v[3] = 1'b0;
    test_reset();
    test_first_lock();
    test_relock();
    test_no_match();
    test_restart_and_reset();
    test_back_to_back();
    test_interlace();
    test_reset_in_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
